// File: rtl/mult_pkg.sv
// Shared types and bounds for the shift-add multiplier.
// Holds the FSM state encoding and the legal WIDTH range.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/mult_ctrl.sv
// Control FSM and iteration counter for the shift-add multiplier.
// Ports: clk, reset (sync, active-low), start, lsb (qreg[0]),
// zero (shifted qreg is zero); strobes load, add_en, shift, out_en;
// busy.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH      = 24,
  parameter int EARLY_EXIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic lsb,
  input  logic zero,
  output logic load,
  output logic add_en,
  output logic shift,
  output logic out_en,
  output logic busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] count;
  logic          last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= nxt;
      if (load)
        count <= '0;
      else if (shift)
        count <= count + CW'(1);
    end
  end

  // last CALC cycle: this shift empties the multiplier
  // (early exit only) or this is iteration WIDTH
  always_comb begin
    last = (count == CW'(WIDTH - 1));
    if (EARLY_EXIT != 0 && zero)
      last = 1'b1;
  end

  always_comb begin
    nxt    = state;
    load   = 1'b0;
    add_en = 1'b0;
    shift  = 1'b0;
    out_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          nxt = LOAD;
      end
      LOAD: begin
        load = 1'b1;
        nxt  = CALC;
      end
      CALC: begin
        shift  = 1'b1;
        add_en = lsb;
        if (last)
          nxt = DONE;
      end
      DONE: begin
        out_en = 1'b1;
        nxt    = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier.
// Ports: clk, reset (sync, active-low), start, a, b in;
// product (2*WIDTH), busy, done (one-cycle pulse) out.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH      = 24,
  parameter int EARLY_EXIT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("shift_add_mult: WIDTH out of range");
    end
  endgenerate

  logic [2*WIDTH-1:0] mreg;
  logic [WIDTH-1:0]   qreg;
  logic               load;
  logic               add_en;
  logic               shift;
  logic               out_en;
  logic               zero;

  assign zero = ((qreg >> 1) == '0);

  mult_ctrl #(
    .WIDTH      (WIDTH),
    .EARLY_EXIT (EARLY_EXIT)
  ) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .lsb    (qreg[0]),
    .zero   (zero),
    .load   (load),
    .add_en (add_en),
    .shift  (shift),
    .out_en (out_en),
    .busy   (busy)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      mreg    <= '0;
      qreg    <= '0;
      product <= '0;
    end else if (load) begin
      mreg    <= {{WIDTH{1'b0}}, a};
      qreg    <= b;
      product <= '0;
    end else if (shift) begin
      if (add_en)
        product <= product + mreg;
      mreg <= mreg << 1;
      qreg <= qreg >> 1;
    end
  end

  assign done = out_en;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and random checks for shift_add_mult.
// Three instances: W8 early-exit, W8 full-run, W24 early-exit.
module tb_shift_add_mult;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  st;
  logic [31:0] av [3];
  logic [31:0] bv [3];
  logic [15:0] p0, p1;
  logic [47:0] p2;
  logic [2:0]  bsy, dn;

  int checks;
  int fails;

  shift_add_mult #(.WIDTH(8), .EARLY_EXIT(1)) u_e8 (
    .clk(clk), .reset(rst[0]), .start(st[0]),
    .a(av[0][7:0]), .b(bv[0][7:0]),
    .product(p0), .busy(bsy[0]), .done(dn[0])
  );

  shift_add_mult #(.WIDTH(8), .EARLY_EXIT(0)) u_f8 (
    .clk(clk), .reset(rst[1]), .start(st[1]),
    .a(av[1][7:0]), .b(bv[1][7:0]),
    .product(p1), .busy(bsy[1]), .done(dn[1])
  );

  shift_add_mult #(.WIDTH(24), .EARLY_EXIT(1)) u_e24 (
    .clk(clk), .reset(rst[2]), .start(st[2]),
    .a(av[2][23:0]), .b(bv[2][23:0]),
    .product(p2), .busy(bsy[2]), .done(dn[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] prod_of(input int s);
    case (s)
      0:       return {48'd0, p0};
      1:       return {48'd0, p1};
      default: return {16'd0, p2};
    endcase
  endfunction

  function automatic int kexp(input int w, input bit ee,
                              input logic [31:0] b);
    if (!ee) return w;
    for (int i = w - 1; i >= 0; i--)
      if (b[i]) return i + 1;
    return 1;
  endfunction

  // lat = edges from start-sampling edge through the edge
  // that samples done high
  task automatic run_op(input int s,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output logic [63:0] p,
                        output int lat);
    logic d;
    @(negedge clk);
    st[s] = 1'b1;
    av[s] = a;
    bv[s] = b;
    @(posedge clk);
    lat = 0;
    p   = '0;
    d   = 1'b0;
    while (!d && lat < 200) begin
      @(negedge clk);
      if (lat == 0) st[s] = 1'b0;
      d = dn[s];
      p = prod_of(s);
      @(posedge clk);
      lat++;
    end
    if (!d) chk("timeout", 64'(lat), 64'd0);
  endtask

  task automatic count_dones(input int s, input int n,
                             output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (dn[s]) cnt++;
    end
  endtask

  logic [63:0] p;
  int          lat;
  int          nd;
  logic [31:0] ra, rb;

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 3'b000;
    st     = 3'b000;
    for (int i = 0; i < 3; i++) begin
      av[i] = '0;
      bv[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_prod", prod_of(0), 64'd0);
    chk("rst_busy", 64'(bsy[0]), 64'd0);
    chk("rst_done", 64'(dn[0]), 64'd0);
    chk("rst_prod24", prod_of(2), 64'd0);
    @(negedge clk);
    rst = 3'b111;

    run_op(0, 13, 11, p, lat);
    chk("13x11", p, 64'd143);
    chk("13x11_lat", 64'(lat), 64'd6);

    run_op(0, 255, 255, p, lat);
    chk("255x255", p, 64'd65025);
    chk("255x255_lat", 64'(lat), 64'd10);

    run_op(1, 3, 1, p, lat);
    chk("ee0_3x1", p, 64'd3);
    chk("ee0_3x1_lat", 64'(lat), 64'd10);

    run_op(0, 200, 0, p, lat);
    chk("200x0", p, 64'd0);
    chk("200x0_lat", 64'(lat), 64'd3);

    run_op(0, 0, 5, p, lat);
    chk("0x5", p, 64'd0);
    chk("0x5_lat", 64'(lat), 64'd5);

    run_op(0, 128, 128, p, lat);
    chk("128x128", p, 64'd16384);
    chk("128x128_lat", 64'(lat), 64'd10);

    // start pulse and operand change while CALC runs
    fork
      run_op(0, 13, 11, p, lat);
      begin
        repeat (3) @(negedge clk);
        st[0] = 1'b1;
        av[0] = 7;
        bv[0] = 9;
        @(negedge clk);
        st[0] = 1'b0;
      end
    join
    chk("ign_prod", p, 64'd143);
    chk("ign_lat", 64'(lat), 64'd6);
    count_dones(0, 15, nd);
    chk("ign_no_2nd_done", 64'(nd), 64'd0);
    chk("ign_hold", prod_of(0), 64'd143);

    // abort mid-CALC
    @(negedge clk);
    st[0] = 1'b1;
    av[0] = 255;
    bv[0] = 255;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_prod", prod_of(0), 64'd0);
    chk("abort_busy", 64'(bsy[0]), 64'd0);
    chk("abort_done", 64'(dn[0]), 64'd0);
    @(negedge clk);
    rst[0] = 1'b1;
    count_dones(0, 15, nd);
    chk("abort_no_done", 64'(nd), 64'd0);
    run_op(0, 13, 11, p, lat);
    chk("post_abort", p, 64'd143);
    chk("post_abort_lat", 64'(lat), 64'd6);

    // random 24-bit pairs, varied multiplier lengths
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom & 32'h00ff_ffff;
      rb = ($urandom & 32'h00ff_ffff) >> $urandom_range(0, 24);
      run_op(2, ra, rb, p, lat);
      chk("rnd_prod", p, 64'(ra) * 64'(rb));
      chk("rnd_lat", 64'(lat), 64'(2 + kexp(24, 1'b1, rb)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter WIDTH, default 24, operand width in bits; legal range 2..32.
REQ-002 Parameter EARLY_EXIT, default 1; 1 ends iteration once the remaining multiplier is zero, 0 always runs WIDTH iterations.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous active-low reset; sampled on the rising edge of clk.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a  input  WIDTH  multiplicand, unsigned; captured on accepted start.
REQ-007 b  input  WIDTH  multiplier, unsigned; captured on accepted start.
REQ-008 product  output  2*WIDTH  result register; holds its value until the next LOAD.
REQ-009 busy  output  1  high in LOAD, CALC and DONE.
REQ-010 done  output  1  one-cycle pulse in DONE; product is valid in that cycle.

Function
REQ-011 FSM states are IDLE, LOAD, CALC and DONE.
REQ-012 Transitions:
- IDLE->LOAD when start=1.
- LOAD->CALC unconditionally.
- CALC->DONE on the exit condition (REQ-015).
- DONE->IDLE unconditionally.
REQ-013 LOAD actions:
- mreg <= zero-extend(a) to 2*WIDTH.
- qreg <= b.
- product <= 0.
- count <= 0.
REQ-014 Each CALC cycle:
- if qreg[0]=1, product <= product + mreg, modulo 2^(2*WIDTH); cannot overflow for unsigned operands.
- mreg <= mreg << 1.
- qreg <= qreg >> 1.
- count <= count + 1.
REQ-015 CALC exit condition:
- EARLY_EXIT=1: shifted qreg == 0, or count+1 == WIDTH.
- EARLY_EXIT=0: count+1 == WIDTH only.
REQ-016 Latency from the start-sampling edge to the done pulse is 2+k cycles.
- k = number of CALC cycles.
- EARLY_EXIT=1: k = max(1, bit index of b's highest set bit + 1).
- EARLY_EXIT=0: k = WIDTH.
REQ-017 start is ignored while busy=1; no queuing, and operands are not re-captured.
REQ-018 start held high continuously restarts a new operation on the IDLE cycle after each DONE, using a and b sampled at that edge.
REQ-019 b=0 yields product=0 after k=1; a=0 yields product=0 with normal k.
REQ-020 Changes to a or b after LOAD have no effect on the running operation.
REQ-021 count width is clog2(WIDTH)+1; count never wraps within an operation.

Reset
REQ-022 reset=0 at a rising edge forces state=IDLE, product=0, mreg=0, qreg=0, count=0, busy=0, done=0, in any state including mid-CALC.
REQ-023 An aborted operation never produces a done pulse.
REQ-024 The first start is accepted on the first edge with reset=1.

Structure
REQ-025 A shared package mult_pkg holds the state enumeration (IDLE=0, LOAD=1, CALC=2, DONE=3) and the WIDTH legality bounds.
REQ-026 Control and datapath are split: sub-module mult_ctrl holds the FSM and count and drives the strobes load, add_en, shift and out_en; shift_add_mult instantiates mult_ctrl and holds mreg, qreg and product.
REQ-027 mult_ctrl receives qreg[0] as lsb and a (shifted qreg == 0) flag as zero.

Verification
REQ-028 WIDTH=8, EARLY_EXIT=1, a=13, b=11 -> product=143, k=4, done 6 cycles after start.
REQ-029 WIDTH=8, a=255, b=255 -> product=65025, k=8, done 10 cycles after start; repeat with EARLY_EXIT=0, a=3, b=1 -> product=3, k=8.
REQ-030 WIDTH=8, a=200, b=0 -> product=0, k=1, done 3 cycles after start.
REQ-031 Pulse start during CALC with different operands -> ignored; first result is unchanged and there is no second done.
REQ-032 reset=0 for one cycle mid-CALC -> all outputs 0 next cycle, no done; a new start then gives the correct result.
REQ-033 WIDTH=24 random unsigned pairs (at least 1000) -> product equals the reference a*b and latency matches REQ-016 for every pair.
